operand_feeder: RTL and testbench
=================================

OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 2: operand width, matching the multiplier x_value port.
REQ-002 SHALL have parameter DEPTH, default 16: operand buffer entries, power of two.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port load_valid, input, 1: load_data is valid this cycle.
REQ-006 SHALL have port load_data, input, WIDTH: operand to buffer.
REQ-007 SHALL have port load_ready, output, 1: buffer accepts a load this cycle.
REQ-008 SHALL have port start, input, 1: one-cycle command (IDLE->SERVE, DONE->IDLE).
REQ-009 SHALL have port ri, input, 1: multiplier read indicator requesting the next operand.
REQ-010 SHALL have port x_value, output, WIDTH: operand presented to the multiplier, registered.
REQ-011 SHALL have port x_valid, output, 1: one-cycle pulse marking that x_value was just updated.
REQ-012 SHALL have port served_cnt, output, log2(DEPTH)+1: operands served since the last start from IDLE.
REQ-013 SHALL have port underflow, output, 1: sticky flag, ri seen with no operand available.
REQ-014 SHALL have port busy, output, 1: high in SERVE.
REQ-015 SHALL have port done, output, 1: high in DONE.

Function
REQ-016 SHALL implement states IDLE, SERVE and DONE.
REQ-017 SHALL in IDLE: load_ready = !full; a write occurs when load_valid && load_ready, in FIFO order.
REQ-018 SHALL drive load_ready low in SERVE and DONE; load_valid there is ignored with no write.
REQ-019 SHALL in IDLE on start: go to SERVE and clear served_cnt and underflow if the buffer is non-empty after this cycle's write; otherwise ignore start.
REQ-020 SHALL when start and a load coincide in IDLE: perform the write, and count it toward the non-empty test.
REQ-021 SHALL in SERVE, when ri is sampled high and the buffer is non-empty: pop the head, on the next edge set x_value = head, pulse x_valid, and increment served_cnt (latency 1 cycle).
REQ-022 SHALL hold x_value between pops; x_valid is low on every cycle without a pop.
REQ-023 SHALL go SERVE->DONE on the edge where a pop empties the buffer.
REQ-024 SHALL in DONE on ri: set underflow; x_value holds; no x_valid pulse.
REQ-025 SHALL in DONE on start: go to IDLE; underflow and served_cnt are held until the next accepted start.
REQ-026 SHALL ignore start in SERVE.
REQ-027 SHALL keep the count exact at full (DEPTH) and empty (0); pointers wrap modulo DEPTH; served_cnt never exceeds DEPTH.

Reset
REQ-028 SHALL on rst (synchronous, priority over all inputs, effective mid-operation) set: state IDLE, buffer empty, pointers 0, x_value 0, x_valid 0, served_cnt 0, underflow 0.
REQ-029 SHALL have registered outputs equal to the reset values in the first cycle after rst deasserts, with load_ready = 1.

Structure
REQ-030 SHALL take WIDTH and DEPTH defaults and the state encoding (IDLE=2'b00, SERVE=2'b01, DONE=2'b10) from shared package newton_pkg.
REQ-031 SHALL implement the buffer as sub-module operand_fifo (push, pop, data, full, empty, count); the control FSM stays in operand_feeder.

Verification
REQ-032 SHALL cover: load 2'b01, 2'b10, 2'b11, then start, then ri on three consecutive cycles -> x_value 01/10/11 one cycle after each ri, three x_valid pulses, served_cnt=3, DONE after the third pop.
REQ-033 SHALL cover: 16 loads -> load_ready low after the 16th; a 17th load_valid is dropped; served_cnt reaches 16 with no wrap.
REQ-034 SHALL cover: start with an empty buffer -> stays IDLE, busy=0.
REQ-035 SHALL cover: ri in DONE -> underflow=1, x_value unchanged, no x_valid; then start -> IDLE with underflow still 1, which clears only on the next accepted start.
REQ-036 SHALL cover: rst asserted in SERVE with 5 entries pending -> next cycle IDLE, empty, all outputs 0, load_ready=1.
REQ-037 SHALL cover: load_valid and start in the same IDLE cycle with an empty buffer -> write accepted, SERVE entered, the first ri returns that operand.

Source files
------------

// File: rtl/newton_pkg.sv
// newton_pkg: shared definitions for the operand feeder.
// Holds the default operand width and buffer depth, and the
// encoding of the feeder control states.
package newton_pkg;

    localparam int FEED_WIDTH_DEF = 2;
    localparam int FEED_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SERVE = 2'b01,
        ST_DONE  = 2'b10
    } feed_state_e;

endpackage : newton_pkg

// File: rtl/operand_fifo.sv
// operand_fifo: DEPTH-entry FIFO buffer for multiplier operands.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   push, push_data     - write request and data (ignored when full)
//   pop                 - remove the head entry (ignored when empty)
//   head                - current head entry (valid when !empty)
//   full, empty, count  - occupancy status; count spans 0..DEPTH
module operand_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == CNT_W'(0));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next pointer/count values; pointers wrap naturally at DEPTH.
    always_comb begin
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s && !do_pop_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop_s && !do_push_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule : operand_fifo

// File: rtl/operand_feeder.sv
// operand_feeder: buffers operands while IDLE, then feeds them one per
// read-indicator request to a multiplier while SERVE, ending in DONE.
// Ports:
//   clk, rst               - clock, synchronous active-high reset
//   load_valid/data/ready  - operand load handshake (accepted only in IDLE)
//   start                  - IDLE->SERVE (if operands exist), DONE->IDLE
//   ri                     - multiplier request for the next operand
//   x_value, x_valid       - registered operand and its one-cycle update pulse
//   served_cnt             - operands served since the last accepted start
//   underflow              - sticky: ri arrived in DONE with nothing left
//   busy, done             - state indicators for SERVE and DONE
module operand_feeder
    import newton_pkg::*;
#(
    parameter int WIDTH = FEED_WIDTH_DEF,
    parameter int DEPTH = FEED_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    input  logic [WIDTH-1:0]           load_data,
    output logic                       load_ready,
    input  logic                       start,
    input  logic                       ri,
    output logic [WIDTH-1:0]           x_value,
    output logic                       x_valid,
    output logic [$clog2(DEPTH):0]     served_cnt,
    output logic                       underflow,
    output logic                       busy,
    output logic                       done
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    feed_state_e      state_q, state_d;
    logic [WIDTH-1:0] x_value_q, x_value_d;
    logic             x_valid_q, x_valid_d;
    logic [CNT_W-1:0] served_cnt_q, served_cnt_d;
    logic             underflow_q, underflow_d;

    logic             push_s;
    logic             pop_s;
    logic             load_ready_s;
    logic [WIDTH-1:0] fifo_head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;

    operand_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (load_data),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Control FSM: next state, buffer strobes and next output values.
    always_comb begin
        state_d      = state_q;
        x_value_d    = x_value_q;
        x_valid_d    = 1'b0;
        served_cnt_d = served_cnt_q;
        underflow_d  = underflow_q;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        load_ready_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_ready_s = !fifo_full_s;
                push_s       = load_valid && load_ready_s;
                // A same-cycle load counts toward the non-empty test.
                if (start && (!fifo_empty_s || push_s)) begin
                    state_d      = ST_SERVE;
                    served_cnt_d = CNT_W'(0);
                    underflow_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (ri && !fifo_empty_s) begin
                    pop_s        = 1'b1;
                    x_value_d    = fifo_head_s;
                    x_valid_d    = 1'b1;
                    served_cnt_d = served_cnt_q + CNT_W'(1);
                    // Last entry leaving: buffer is empty after this edge.
                    if (fifo_count_s == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SERVE;
                    end
                end else begin
                    state_d = ST_SERVE;
                end
            end
            ST_DONE: begin
                if (ri) begin
                    underflow_d = 1'b1;
                end else begin
                    underflow_d = underflow_q;
                end
                if (start) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            x_value_q    <= WIDTH'(0);
            x_valid_q    <= 1'b0;
            served_cnt_q <= CNT_W'(0);
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_value_q    <= x_value_d;
            x_valid_q    <= x_valid_d;
            served_cnt_q <= served_cnt_d;
            underflow_q  <= underflow_d;
        end
    end

    assign load_ready = load_ready_s;
    assign x_value    = x_value_q;
    assign x_valid    = x_valid_q;
    assign served_cnt = served_cnt_q;
    assign underflow  = underflow_q;
    assign busy       = (state_q == ST_SERVE);
    assign done       = (state_q == ST_DONE);

endmodule : operand_feeder

// File: tb/tb_operand_feeder.sv
// tb_operand_feeder: directed scenarios plus random stimulus, every
// output compared each cycle against a queue-based reference model.
module tb_operand_feeder;

    localparam int WIDTH = 2;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_data = '0;
    logic             load_ready;
    logic             start = 1'b0;
    logic             ri = 1'b0;
    logic [WIDTH-1:0] x_value;
    logic             x_valid;
    logic [4:0]       served_cnt;
    logic             underflow;
    logic             busy;
    logic             done;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: operands in a queue, a mode (0 idle, 1 serving,
    // 2 finished) and the expected visible outputs.
    int q_m[$];
    int mode_m  = 0;
    int xv_m    = 0;
    int xval_m  = 0;
    int cnt_m   = 0;
    int uf_m    = 0;

    operand_feeder #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .start      (start),
        .ri         (ri),
        .x_value    (x_value),
        .x_valid    (x_valid),
        .served_cnt (served_cnt),
        .underflow  (underflow),
        .busy       (busy),
        .done       (done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("x_value",    32'(x_value),    32'(xv_m));
        check_eq("x_valid",    32'(x_valid),    32'(xval_m));
        check_eq("served_cnt", 32'(served_cnt), 32'(cnt_m));
        check_eq("underflow",  32'(underflow),  32'(uf_m));
        check_eq("busy",       32'(busy),       32'(mode_m == 1));
        check_eq("done",       32'(done),       32'(mode_m == 2));
        check_eq("load_ready", 32'(load_ready), 32'((mode_m == 0) && (q_m.size() < DEPTH)));
    endtask

    // Apply one cycle of inputs, advance the model, then compare.
    task automatic step(input logic lv, input logic [WIDTH-1:0] ld,
                        input logic st, input logic r, input logic rs);
        load_valid = lv;
        load_data  = ld;
        start      = st;
        ri         = r;
        rst        = rs;
        if (rs) begin
            q_m.delete();
            mode_m = 0; xv_m = 0; xval_m = 0; cnt_m = 0; uf_m = 0;
        end else begin
            xval_m = 0;
            if (mode_m == 0) begin
                if (lv && q_m.size() < DEPTH) q_m.push_back(int'(ld));
                if (st && q_m.size() > 0) begin
                    mode_m = 1; cnt_m = 0; uf_m = 0;
                end
            end else if (mode_m == 1) begin
                if (r && q_m.size() > 0) begin
                    xv_m = q_m.pop_front();
                    xval_m = 1;
                    cnt_m++;
                    if (q_m.size() == 0) mode_m = 2;
                end
            end else begin
                if (r) uf_m = 1;
                if (st) mode_m = 0;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        // Reset, then the first cycle after release shows reset values.
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        check_eq("post_reset_ready", 32'(load_ready), 32'd1);

        // Three loads, start, three back-to-back requests.
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check_eq("seq3_first", 32'(x_value), 32'd1);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check_eq("seq3_second", 32'(x_value), 32'd2);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check_eq("seq3_third", 32'(x_value), 32'd3);
        check_eq("seq3_cnt", 32'(served_cnt), 32'd3);
        check_eq("seq3_done", 32'(done), 32'd1);

        // Fill to DEPTH, drop a 17th, serve all 16.
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0);
        check_eq("full_ready_low", 32'(load_ready), 32'd0);
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check_eq("full_cnt16", 32'(served_cnt), 32'd16);
        check_eq("full_done", 32'(done), 32'd1);

        // Request in DONE: underflow sticks across the return to IDLE.
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check_eq("uf_set", 32'(underflow), 32'd1);
        check_eq("uf_no_valid", 32'(x_valid), 32'd0);
        check_eq("uf_x_hold", 32'(x_value), 32'd3);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        check_eq("uf_idle_kept", 32'(underflow), 32'd1);
        step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        check_eq("uf_cleared", 32'(underflow), 32'd0);

        // Start with an empty buffer is ignored.
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        check_eq("empty_start_busy", 32'(busy), 32'd0);

        // Reset in SERVE with five entries pending.
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(i + 1), 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        check_eq("serve5_busy", 32'(busy), 32'd1);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        check_eq("rst_mid_ready", 32'(load_ready), 32'd1);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);

        // Load and start in the same cycle from empty.
        step(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        check_eq("coincide_busy", 32'(busy), 32'd1);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        check_eq("coincide_val", 32'(x_value), 32'd2);
        check_eq("coincide_done", 32'(done), 32'd1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), WIDTH'($urandom),
                 1'($urandom_range(0, 99) < 8), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) < 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_operand_feeder
